raytracer_pixel_shader: RTL

// - Per-pixel shading engine; successor to the fixed single-ray raytracer top.
// - Accepts one ray per pixel over valid/ready, scans all spheres sequentially for nearest hit,

---
 rtl/raytracer_pixel_shader.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/raytracer_pixel_shader.sv
// raytracer_pixel_shader: per-pixel nearest-sphere search followed by diffuse shading.
// One ray is accepted per pixel, every sphere is scanned (one per cycle) through the external
// scene LUT / intersect unit, then every light is applied (one per cycle) and a saturated RGB
// result is offered on a valid/ready output.
// Optional feature: define RT_DEPTH_OUT_EN to add out_depth_o (best t on hit, all-ones on miss).
module raytracer_pixel_shader #(
    parameter int unsigned W         = 12,
    parameter int unsigned FRAC      = 4,
    parameter int unsigned N_SPHERES = 8,
    parameter int unsigned N_LIGHTS  = 4,
    parameter int unsigned AMBIENT   = 2,
    parameter int unsigned BG_R      = 0,
    parameter int unsigned BG_G      = 0,
    parameter int unsigned BG_B      = 32,
    localparam int unsigned SW = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1,
    localparam int unsigned LW = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [9:0]    in_px_i,
    input  logic [9:0]    in_py_i,
    input  logic [W-1:0]  in_ox_i,
    input  logic [W-1:0]  in_oy_i,
    input  logic [W-1:0]  in_oz_i,
    input  logic [W-1:0]  in_dx_i,
    input  logic [W-1:0]  in_dy_i,
    input  logic [W-1:0]  in_dz_i,
    output logic [W-1:0]  ray_ox_o,
    output logic [W-1:0]  ray_oy_o,
    output logic [W-1:0]  ray_oz_o,
    output logic [W-1:0]  ray_dx_o,
    output logic [W-1:0]  ray_dy_o,
    output logic [W-1:0]  ray_dz_o,
    output logic [SW-1:0] sph_idx_o,
    input  logic [W-1:0]  sph_cx_i,
    input  logic [W-1:0]  sph_cy_i,
    input  logic [W-1:0]  sph_cz_i,
    input  logic [W-1:0]  sph_rad_i,
    input  logic [7:0]    sph_r_i,
    input  logic [7:0]    sph_g_i,
    input  logic [7:0]    sph_b_i,
    input  logic          isect_hit_i,
    input  logic [W-1:0]  isect_t_i,
    output logic [LW-1:0] lgt_idx_o,
    input  logic [W-1:0]  lgt_x_i,
    input  logic [W-1:0]  lgt_y_i,
    input  logic [W-1:0]  lgt_z_i,
    input  logic [7:0]    lgt_r_i,
    input  logic [7:0]    lgt_g_i,
    input  logic [7:0]    lgt_b_i,
    input  logic [W-1:0]  lgt_int_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [9:0]    out_px_o,
    output logic [9:0]    out_py_o,
`ifdef RT_DEPTH_OUT_EN
    output logic [W-1:0]  out_depth_o,
`endif
    output logic [7:0]    rgb_r_o,
    output logic [7:0]    rgb_g_o,
    output logic [7:0]    rgb_b_o
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSearch = 3'd1;
    localparam logic [2:0] StHitpt  = 3'd2;
    localparam logic [2:0] StLight  = 3'd3;
    localparam logic [2:0] StOut    = 3'd4;

    localparam int unsigned DW = 2 * W + 4;      // dot-product width
    localparam int unsigned PW = DW + W;         // dot * intensity width
    localparam int unsigned CW = FRAC + 17;      // colour * diffuse width
    localparam logic [SW-1:0] LastSph = SW'(N_SPHERES - 1);
    localparam logic [LW-1:0] LastLgt = LW'((N_LIGHTS > 0) ? N_LIGHTS - 1 : 0);
    localparam logic [PW-1:0] OneP    = PW'(1) << FRAC;
    localparam logic [FRAC:0] OneD    = (FRAC + 1)'(1) << FRAC;

    logic [2:0]    state_q, state_d;
    logic [W-1:0]  ray_ox_q, ray_oy_q, ray_oz_q, ray_dx_q, ray_dy_q, ray_dz_q;
    logic [W-1:0]  ray_ox_d, ray_oy_d, ray_oz_d, ray_dx_d, ray_dy_d, ray_dz_d;
    logic [9:0]    px_q, py_q, px_d, py_d;
    logic [SW-1:0] sph_idx_q, sph_idx_d;
    logic [LW-1:0] lgt_idx_q, lgt_idx_d;
    logic          best_valid_q, best_valid_d;
    logic [W-1:0]  best_t_q, best_t_d;
    logic [W-1:0]  best_cx_q, best_cy_q, best_cz_q, best_cx_d, best_cy_d, best_cz_d;
    logic [7:0]    best_r_q, best_g_q, best_b_q, best_r_d, best_g_d, best_b_d;
    logic [W-1:0]  hit_x_q, hit_y_q, hit_z_q, hit_x_d, hit_y_d, hit_z_d;
    logic [W:0]    nrm_x_q, nrm_y_q, nrm_z_q, nrm_x_d, nrm_y_d, nrm_z_d;
    logic [17:0]   acc_r_q, acc_g_q, acc_b_q, acc_r_d, acc_g_d, acc_b_d;
    logic          out_valid_q, out_valid_d;
    logic [9:0]    out_px_q, out_py_q, out_px_d, out_py_d;
    logic [7:0]    rgb_r_q, rgb_g_q, rgb_b_q, rgb_r_d, rgb_g_d, rgb_b_d;
    logic [W-1:0]  depth_q, depth_d;

    // Sign-extend a (W+1)-bit vector to the dot-product width.
    function automatic logic [DW-1:0] sx_dw(input logic [W:0] v);
        return {{(DW - W - 1){v[W]}}, v};
    endfunction

    // ((col * light_col) >> 8) * diffuse >> FRAC for one channel.
    function automatic logic [17:0] shade(input logic [7:0] c, input logic [7:0] lc,
                                          input logic [FRAC:0] df);
        logic [CW-1:0] p;
        p = ((CW'(c) * CW'(lc)) >> 8) * CW'(df);
        return 18'(p >> FRAC);
    endfunction

    // Accumulate without wrapping.
    function automatic logic [17:0] sat_add(input logic [17:0] a, input logic [17:0] b);
        logic [18:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[18] ? 18'h3FFFF : s[17:0];
    endfunction

    function automatic logic [17:0] ambient(input logic [7:0] c);
        logic [17:0] p;
        p = {10'b0, c} * 18'(AMBIENT);
        return p >> FRAC;
    endfunction

    function automatic logic [7:0] sat8(input logic [17:0] a);
        return (|a[17:8]) ? 8'hFF : a[7:0];
    endfunction

    // Nearest-hit candidate test for the sphere currently addressed.
    logic cand;
    assign cand = isect_hit_i && ($signed(isect_t_i) > 0) &&
                  (!best_valid_q || ($signed(isect_t_i) < $signed(best_t_q)));

    // Hit point and surface normal from the winning sphere.
    logic [2*W-1:0] hp_x, hp_y, hp_z;
    logic [W-1:0]   hn_x, hn_y, hn_z;
    assign hp_x = {{W{ray_dx_q[W-1]}}, ray_dx_q} * {{W{best_t_q[W-1]}}, best_t_q};
    assign hp_y = {{W{ray_dy_q[W-1]}}, ray_dy_q} * {{W{best_t_q[W-1]}}, best_t_q};
    assign hp_z = {{W{ray_dz_q[W-1]}}, ray_dz_q} * {{W{best_t_q[W-1]}}, best_t_q};
    assign hn_x = ray_ox_q + W'($signed(hp_x) >>> FRAC);
    assign hn_y = ray_oy_q + W'($signed(hp_y) >>> FRAC);
    assign hn_z = ray_oz_q + W'($signed(hp_z) >>> FRAC);

    // Diffuse factor for the light currently addressed.
    logic [W:0]      l_x, l_y, l_z;
    logic [DW-1:0]   nl_x, nl_y, nl_z, ndotl;
    logic [PW-1:0]   dprod, dshift;
    logic            ndotl_pos, int_pos;
    logic [FRAC:0]   diff;
    assign l_x = {lgt_x_i[W-1], lgt_x_i} - {hit_x_q[W-1], hit_x_q};
    assign l_y = {lgt_y_i[W-1], lgt_y_i} - {hit_y_q[W-1], hit_y_q};
    assign l_z = {lgt_z_i[W-1], lgt_z_i} - {hit_z_q[W-1], hit_z_q};
    assign nl_x = $signed(sx_dw(nrm_x_q) * sx_dw(l_x)) >>> FRAC;
    assign nl_y = $signed(sx_dw(nrm_y_q) * sx_dw(l_y)) >>> FRAC;
    assign nl_z = $signed(sx_dw(nrm_z_q) * sx_dw(l_z)) >>> FRAC;
    assign ndotl = nl_x + nl_y + nl_z;
    assign ndotl_pos = !ndotl[DW-1] && (|ndotl);
    assign int_pos = !lgt_int_i[W-1] && (|lgt_int_i);
    assign dprod = {{W{ndotl[DW-1]}}, ndotl} * {{DW{lgt_int_i[W-1]}}, lgt_int_i};
    assign dshift = $signed(dprod) >>> FRAC;

    // Clamp diffuse to [0, 1.0]; back-facing or non-positive intensity contributes nothing.
    always_comb begin
        diff = '0;
        if (ndotl_pos && int_pos) begin
            diff = (dshift >= OneP) ? OneD : dshift[FRAC:0];
        end
    end

    // Radius is consumed by the external intersect unit only.
    logic unused_rad;
    assign unused_rad = ^sph_rad_i;

    // Next-state logic for the pixel FSM and datapath registers.
    always_comb begin
        state_d      = state_q;
        ray_ox_d     = ray_ox_q;
        ray_oy_d     = ray_oy_q;
        ray_oz_d     = ray_oz_q;
        ray_dx_d     = ray_dx_q;
        ray_dy_d     = ray_dy_q;
        ray_dz_d     = ray_dz_q;
        px_d         = px_q;
        py_d         = py_q;
        sph_idx_d    = sph_idx_q;
        lgt_idx_d    = lgt_idx_q;
        best_valid_d = best_valid_q;
        best_t_d     = best_t_q;
        best_cx_d    = best_cx_q;
        best_cy_d    = best_cy_q;
        best_cz_d    = best_cz_q;
        best_r_d     = best_r_q;
        best_g_d     = best_g_q;
        best_b_d     = best_b_q;
        hit_x_d      = hit_x_q;
        hit_y_d      = hit_y_q;
        hit_z_d      = hit_z_q;
        nrm_x_d      = nrm_x_q;
        nrm_y_d      = nrm_y_q;
        nrm_z_d      = nrm_z_q;
        acc_r_d      = acc_r_q;
        acc_g_d      = acc_g_q;
        acc_b_d      = acc_b_q;
        out_valid_d  = out_valid_q;
        out_px_d     = out_px_q;
        out_py_d     = out_py_q;
        rgb_r_d      = rgb_r_q;
        rgb_g_d      = rgb_g_q;
        rgb_b_d      = rgb_b_q;
        depth_d      = depth_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    ray_ox_d     = in_ox_i;
                    ray_oy_d     = in_oy_i;
                    ray_oz_d     = in_oz_i;
                    ray_dx_d     = in_dx_i;
                    ray_dy_d     = in_dy_i;
                    ray_dz_d     = in_dz_i;
                    px_d         = in_px_i;
                    py_d         = in_py_i;
                    sph_idx_d    = '0;
                    best_valid_d = 1'b0;
                    state_d      = StSearch;
                end
            end
            StSearch: begin
                if (cand) begin
                    best_valid_d = 1'b1;
                    best_t_d     = isect_t_i;
                    best_cx_d    = sph_cx_i;
                    best_cy_d    = sph_cy_i;
                    best_cz_d    = sph_cz_i;
                    best_r_d     = sph_r_i;
                    best_g_d     = sph_g_i;
                    best_b_d     = sph_b_i;
                end
                if (sph_idx_q == LastSph) begin
                    sph_idx_d = '0;
                    if (best_valid_d) begin
                        state_d = StHitpt;
                    end else begin
                        state_d     = StOut;
                        out_valid_d = 1'b1;
                        out_px_d    = px_q;
                        out_py_d    = py_q;
                        rgb_r_d     = 8'(BG_R);
                        rgb_g_d     = 8'(BG_G);
                        rgb_b_d     = 8'(BG_B);
                        depth_d     = '1;
                    end
                end else begin
                    sph_idx_d = sph_idx_q + 1'b1;
                end
            end
            StHitpt: begin
                hit_x_d   = hn_x;
                hit_y_d   = hn_y;
                hit_z_d   = hn_z;
                nrm_x_d   = {hn_x[W-1], hn_x} - {best_cx_q[W-1], best_cx_q};
                nrm_y_d   = {hn_y[W-1], hn_y} - {best_cy_q[W-1], best_cy_q};
                nrm_z_d   = {hn_z[W-1], hn_z} - {best_cz_q[W-1], best_cz_q};
                acc_r_d   = ambient(best_r_q);
                acc_g_d   = ambient(best_g_q);
                acc_b_d   = ambient(best_b_q);
                lgt_idx_d = '0;
                if (N_LIGHTS == 0) begin
                    state_d     = StOut;
                    out_valid_d = 1'b1;
                    out_px_d    = px_q;
                    out_py_d    = py_q;
                    rgb_r_d     = sat8(acc_r_d);
                    rgb_g_d     = sat8(acc_g_d);
                    rgb_b_d     = sat8(acc_b_d);
                    depth_d     = best_t_q;
                end else begin
                    state_d = StLight;
                end
            end
            StLight: begin
                acc_r_d = sat_add(acc_r_q, shade(best_r_q, lgt_r_i, diff));
                acc_g_d = sat_add(acc_g_q, shade(best_g_q, lgt_g_i, diff));
                acc_b_d = sat_add(acc_b_q, shade(best_b_q, lgt_b_i, diff));
                if (lgt_idx_q == LastLgt) begin
                    lgt_idx_d   = '0;
                    state_d     = StOut;
                    out_valid_d = 1'b1;
                    out_px_d    = px_q;
                    out_py_d    = py_q;
                    rgb_r_d     = sat8(acc_r_d);
                    rgb_g_d     = sat8(acc_g_d);
                    rgb_b_d     = sat8(acc_b_d);
                    depth_d     = best_t_q;
                end else begin
                    lgt_idx_d = lgt_idx_q + 1'b1;
                end
            end
            StOut: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset drops any pixel in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ray_ox_q     <= '0;
            ray_oy_q     <= '0;
            ray_oz_q     <= '0;
            ray_dx_q     <= '0;
            ray_dy_q     <= '0;
            ray_dz_q     <= '0;
            px_q         <= '0;
            py_q         <= '0;
            sph_idx_q    <= '0;
            lgt_idx_q    <= '0;
            best_valid_q <= 1'b0;
            best_t_q     <= '0;
            best_cx_q    <= '0;
            best_cy_q    <= '0;
            best_cz_q    <= '0;
            best_r_q     <= '0;
            best_g_q     <= '0;
            best_b_q     <= '0;
            hit_x_q      <= '0;
            hit_y_q      <= '0;
            hit_z_q      <= '0;
            nrm_x_q      <= '0;
            nrm_y_q      <= '0;
            nrm_z_q      <= '0;
            acc_r_q      <= '0;
            acc_g_q      <= '0;
            acc_b_q      <= '0;
            out_valid_q  <= 1'b0;
            out_px_q     <= '0;
            out_py_q     <= '0;
            rgb_r_q      <= '0;
            rgb_g_q      <= '0;
            rgb_b_q      <= '0;
            depth_q      <= '0;
        end else begin
            state_q      <= state_d;
            ray_ox_q     <= ray_ox_d;
            ray_oy_q     <= ray_oy_d;
            ray_oz_q     <= ray_oz_d;
            ray_dx_q     <= ray_dx_d;
            ray_dy_q     <= ray_dy_d;
            ray_dz_q     <= ray_dz_d;
            px_q         <= px_d;
            py_q         <= py_d;
            sph_idx_q    <= sph_idx_d;
            lgt_idx_q    <= lgt_idx_d;
            best_valid_q <= best_valid_d;
            best_t_q     <= best_t_d;
            best_cx_q    <= best_cx_d;
            best_cy_q    <= best_cy_d;
            best_cz_q    <= best_cz_d;
            best_r_q     <= best_r_d;
            best_g_q     <= best_g_d;
            best_b_q     <= best_b_d;
            hit_x_q      <= hit_x_d;
            hit_y_q      <= hit_y_d;
            hit_z_q      <= hit_z_d;
            nrm_x_q      <= nrm_x_d;
            nrm_y_q      <= nrm_y_d;
            nrm_z_q      <= nrm_z_d;
            acc_r_q      <= acc_r_d;
            acc_g_q      <= acc_g_d;
            acc_b_q      <= acc_b_d;
            out_valid_q  <= out_valid_d;
            out_px_q     <= out_px_d;
            out_py_q     <= out_py_d;
            rgb_r_q      <= rgb_r_d;
            rgb_g_q      <= rgb_g_d;
            rgb_b_q      <= rgb_b_d;
            depth_q      <= depth_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign ray_ox_o    = ray_ox_q;
    assign ray_oy_o    = ray_oy_q;
    assign ray_oz_o    = ray_oz_q;
    assign ray_dx_o    = ray_dx_q;
    assign ray_dy_o    = ray_dy_q;
    assign ray_dz_o    = ray_dz_q;
    assign sph_idx_o   = sph_idx_q;
    assign lgt_idx_o   = lgt_idx_q;
    assign out_valid_o = out_valid_q;
    assign out_px_o    = out_px_q;
    assign out_py_o    = out_py_q;
    assign rgb_r_o     = rgb_r_q;
    assign rgb_g_o     = rgb_g_q;
    assign rgb_b_o     = rgb_b_q;
`ifdef RT_DEPTH_OUT_EN
    assign out_depth_o = depth_q;
`else
    logic unused_depth;
    assign unused_depth = ^depth_q;
`endif

endmodule
